store_align_unit: RTL and testbench
===================================

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the byte-address width.
REQ-002 SHALL have port clk, input, 1 bit, the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit, which indicates a store request from the MEM stage.
REQ-005 SHALL have port req_ready, output, 1 bit, which indicates the unit can accept a request.
REQ-006 SHALL have port req_addr, input, ADDR_W bits, the store byte address.
REQ-007 SHALL have port req_data, input, 32 bits, the rs2 data, right-justified.
REQ-008 SHALL have port req_func3, input, 3 bits, where 000 = sb, 001 = sh and 010 = sw.
REQ-009 SHALL have port mem_valid, output, 1 bit, which indicates a data-memory write beat is presented.
REQ-010 SHALL have port mem_ready, input, 1 bit, which indicates the memory accepts the current beat.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits, a word-aligned address with bits [1:0] = 0.
REQ-012 SHALL have port mem_wdata, output, 32 bits, the lane-aligned write data.
REQ-013 SHALL have port mem_be, output, 4 bits, the byte enables, where bit i enables byte lane i.
REQ-014 SHALL have port store_err, output, 1 bit, a one-cycle pulse flagging an illegal or unsupported store.
REQ-015 SHALL have port busy, output, 1 bit, which is high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, BEAT0 and BEAT1.
REQ-017 SHALL drive req_ready high only in IDLE, so a handshake is req_valid && req_ready sampled on a rising clk edge.
REQ-018 SHALL, on a handshake with a legal func3, register all request fields and enter BEAT0, so that mem_valid rises exactly one cycle after acceptance.
REQ-019 SHALL hold mem_addr, mem_wdata and mem_be stable while mem_valid=1 and mem_ready=0.
REQ-020 SHALL compute off = addr[1:0] and mem_addr = {addr[ADDR_W-1:2], 2'b00}.
REQ-021 SHALL handle sb as a single beat with be = 4'b0001<<off and wdata = data[7:0] placed in lane off, with all other lanes 0.
REQ-022 SHALL handle sh with off 0, 1 or 2 as a single beat with be = 4'b0011<<off and wdata = data[15:0]<<(8*off).
REQ-023 SHALL handle sw with off 0 as a single beat with be = 4'b1111 and wdata = data.
REQ-024 SHALL classify a store as word-crossing when it is sh with off 3 or sw with off 1, 2 or 3.
REQ-025 SHALL, for a single-beat store, return from BEAT0 to IDLE on mem_ready.
REQ-026 SHALL, for a word-crossing store, send BEAT0 with be = (4'b1111<<off) masked to the access size and wdata = data<<(8*off).
REQ-027 SHALL, for a word-crossing store, move from BEAT0 to BEAT1 on mem_ready and present mem_addr + 4 with the remaining bytes in lanes starting at 0, where sw uses be = 4'b1111>>(4-off).
REQ-028 SHALL compute mem_addr + 4 modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-029 SHALL return from BEAT1 to IDLE on mem_ready.
REQ-030 SHALL raise req_ready in the cycle after the final beat is accepted, giving no back-to-back acceptance in the same cycle.
REQ-031 SHALL, on a handshake with func3 not in {000, 001, 010}, pulse store_err for one cycle on the next cycle, issue no memory beat and remain in IDLE.
REQ-032 SHALL drive mem_wdata = 0 and mem_be = 0 whenever mem_valid = 0.

Reset
REQ-033 SHALL, on rst_n low, immediately and asynchronously force state IDLE, mem_valid = 0, mem_be = 0, mem_wdata = 0, mem_addr = 0, store_err = 0 and busy = 0, with req_ready = 1 once the FSM is in IDLE.
REQ-034 SHALL, on reset asserted in BEAT0 or BEAT1, abandon the pending store with no further beats, so a partially written word-crossing store is permitted.
REQ-035 SHALL release reset synchronously to clk at the first rising edge with rst_n high.

Configuration
REQ-036 SHALL, with macro STORE_ALIGN_MISALIGN_SPLIT_EN defined, handle word-crossing stores by splitting them into two beats as in REQ-026 to REQ-029.
REQ-037 SHALL, without STORE_ALIGN_MISALIGN_SPLIT_EN, issue no beat for a word-crossing store, pulse store_err one cycle after acceptance and stay in IDLE, with BEAT1 unreachable.

Verification
REQ-038 SHALL cover an sb at addr 0x103 with data 0x000000AB and mem_ready=1: this produces one beat with mem_addr 0x100, be 1000 and wdata 0xAB000000, followed by IDLE.
REQ-039 SHALL cover an sh at addr 0x202 with data 0x1234 while mem_ready is held 0 for 3 cycles: this produces be 1100 and wdata 0x12340000, held stable for 4 cycles.
REQ-040 SHALL cover an sw at addr 0x301 with data 0xDDCCBBAA and SPLIT_EN defined: this produces beat0 at 0x300 with be 1110 and wdata 0xCCBBAA00, then beat1 at 0x304 with be 0001 and wdata 0x000000DD.
REQ-041 SHALL cover an sw at addr 0xFFFFFFFE with SPLIT_EN defined: beat1 mem_addr is 0x00000000 with be 0011.
REQ-042 SHALL cover the same sw at 0x301 without SPLIT_EN: mem_valid never rises and store_err is high for exactly one cycle.
REQ-043 SHALL cover func3 = 011, and separately rst_n pulsed low while in BEAT1: func3 = 011 gives a store_err pulse and no beat, while the reset pulse gives mem_valid = 0 immediately and req_ready = 1.

Source files
------------

// File: rtl/store_align_unit.sv
// ---------------------------------------------------------------------------
// store_align_unit
//
// Purpose:
//   Turns a RISC-V store (sb/sh/sw) from the MEM stage into one or two
//   word-aligned data-memory write beats with lane-aligned data and byte
//   enables. Illegal func3 codes are rejected with a one-cycle store_err
//   pulse and never reach memory.
//
// Configuration macro:
//   STORE_ALIGN_MISALIGN_SPLIT_EN
//     defined   : word-crossing stores go out as two beats (addr, addr+4)
//     undefined : word-crossing stores are rejected with store_err
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   store request present
//   req_ready  out  unit idle and able to accept a request
//   req_addr   in   store byte address (ADDR_W bits)
//   req_data   in   rs2 data, right-justified
//   req_func3  in   000 sb, 001 sh, 010 sw
//   mem_valid  out  write beat presented
//   mem_ready  in   memory accepts the current beat
//   mem_addr   out  word-aligned beat address
//   mem_wdata  out  lane-aligned write data (0 when no beat)
//   mem_be     out  byte enables, bit i = lane i (0 when no beat)
//   store_err  out  one-cycle pulse for a rejected store
//   busy       out  FSM is not idle
// ---------------------------------------------------------------------------
module store_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        req_func3,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              store_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-3:0]   waddr_q, waddr_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         data_q, data_d;
    logic [3:0]          mask_q, mask_d;
    logic                cross_q, cross_d;
    logic                err_q, err_d;

    logic                reqLegal;
    logic                reqCross;
    logic [3:0]          reqMask;
    logic [31:0]         reqDataSized;
    logic [63:0]         wideData;
    logic [7:0]          wideBe;
    logic [ADDR_W-3:0]   nextWaddr;

    // Decode the incoming request: access-size mask, data trimmed to the
    // access size, and whether the access runs past the end of its word.
    always_comb begin
        reqLegal     = 1'b1;
        reqMask      = 4'b0000;
        reqDataSized = 32'd0;
        case (req_func3)
            3'b000: begin
                reqMask      = 4'b0001;
                reqDataSized = {24'd0, req_data[7:0]};
            end
            3'b001: begin
                reqMask      = 4'b0011;
                reqDataSized = {16'd0, req_data[15:0]};
            end
            3'b010: begin
                reqMask      = 4'b1111;
                reqDataSized = req_data;
            end
            default: reqLegal = 1'b0;
        endcase
        reqCross = ((req_func3 == 3'b001) && (req_addr[1:0] == 2'd3)) ||
                   ((req_func3 == 3'b010) && (req_addr[1:0] != 2'd0));
    end

    // Next-state logic. Request fields are captured only on acceptance;
    // rejected requests raise err for exactly one cycle and stay in IDLE.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        off_d   = off_q;
        data_d  = data_q;
        mask_d  = mask_q;
        cross_d = cross_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!reqLegal) begin
                        err_d = 1'b1;
                    end
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
                    else begin
`else
                    else if (reqCross) begin
                        err_d = 1'b1;
                    end else begin
`endif
                        waddr_d = req_addr[ADDR_W-1:2];
                        off_d   = req_addr[1:0];
                        data_d  = reqDataSized;
                        mask_d  = reqMask;
                        cross_d = reqCross;
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    state_d = cross_q ? BEAT1 : IDLE;
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            off_q   <= 2'd0;
            data_q  <= 32'd0;
            mask_q  <= 4'd0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            off_q   <= off_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cross_q <= cross_d;
            err_q   <= err_d;
        end
    end

    // The store is laid out across a doubleword window: the low half is the
    // first beat, the high half holds whatever spilled into the next word.
    // Outputs depend only on registered state, so they stay stable while
    // the memory stalls and clear immediately on reset.
    always_comb begin
        wideData  = {32'd0, data_q} << {off_q, 3'b000};
        wideBe    = {4'd0, mask_q} << off_q;
        nextWaddr = waddr_q + {{(ADDR_W-3){1'b0}}, 1'b1};
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        case (state_q)
            BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = {waddr_q, 2'b00};
                mem_wdata = wideData[31:0];
                mem_be    = wideBe[3:0];
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = {nextWaddr, 2'b00};
                mem_wdata = wideData[63:32];
                mem_be    = wideBe[7:4];
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign store_err = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// ---------------------------------------------------------------------------
// tb_store_align_unit
//
// Self-checking bench for store_align_unit. The reference model describes a
// store as a list of individual byte writes and groups them by word address
// to obtain the expected beats. Follows STORE_ALIGN_MISALIGN_SPLIT_EN the
// same way the design does.
// ---------------------------------------------------------------------------
module tb_store_align_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [2:0]        req_func3;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              store_err;
    logic              busy;

    int totalChecks = 0;
    int badChecks   = 0;

    // Expected beats for the current store, filled by modelStore.
    logic [31:0] expAddr [2];
    logic [3:0]  expBe   [2];
    logic [31:0] expData [2];
    int          expBeats;
    bit          expErr;

    store_align_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_func3 (req_func3),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .store_err (store_err),
        .busy      (busy)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: a store of N bytes writes byte i of the data to byte
    // address addr+i (wrapping at 2^32). Bytes sharing a word form one beat.
    task automatic modelStore(input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] f3);
        int          size;
        int          lane;
        logic [31:0] byteAddr;
        logic [31:0] wordAddr;
        expErr   = 1'b0;
        expBeats = 0;
        for (int k = 0; k < 2; k++) begin
            expAddr[k] = 32'd0;
            expBe[k]   = 4'd0;
            expData[k] = 32'd0;
        end
        if (f3 > 3'd2) begin
            expErr = 1'b1;
            return;
        end
        size = 1 << f3;
        for (int i = 0; i < size; i++) begin
            byteAddr = addr + 32'(i);
            wordAddr = byteAddr & 32'hFFFF_FFFC;
            lane     = int'(byteAddr & 32'd3);
            if (expBeats == 0 || expAddr[expBeats-1] != wordAddr) begin
                expAddr[expBeats] = wordAddr;
                expBeats++;
            end
            expBe[expBeats-1][lane]           = 1'b1;
            expData[expBeats-1][lane*8 +: 8] = data[i*8 +: 8];
        end
`ifndef STORE_ALIGN_MISALIGN_SPLIT_EN
        if (expBeats > 1) begin
            expErr   = 1'b1;
            expBeats = 0;
        end
`endif
    endtask

    // Issues one store and follows it to completion. stall >= 0 holds
    // mem_ready low for that many cycles of every beat; stall < 0 randomizes.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] f3, input int stall);
        int waits;
        bit done;
        modelStore(addr, data, f3);
        @(negedge clk);
        checkOutput("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_func3 = f3;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = $urandom;
        if (expErr) begin
            @(negedge clk);
            checkOutput("err_pulse", 64'(store_err), 64'd1);
            checkOutput("err_no_valid", 64'(mem_valid), 64'd0);
            checkOutput("err_not_busy", 64'(busy), 64'd0);
            @(negedge clk);
            checkOutput("err_pulse_end", 64'(store_err), 64'd0);
            checkOutput("err_still_no_valid", 64'(mem_valid), 64'd0);
            checkOutput("err_ready", 64'(req_ready), 64'd1);
        end else begin
            for (int b = 0; b < expBeats; b++) begin
                waits = 0;
                done  = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    checkOutput("beat_valid", 64'(mem_valid), 64'd1);
                    checkOutput("beat_addr", 64'(mem_addr), 64'(expAddr[b]));
                    checkOutput("beat_be", 64'(mem_be), 64'(expBe[b]));
                    checkOutput("beat_wdata", 64'(mem_wdata), 64'(expData[b]));
                    checkOutput("beat_busy", 64'(busy), 64'd1);
                    checkOutput("beat_ready_low", 64'(req_ready), 64'd0);
                    checkOutput("beat_no_err", 64'(store_err), 64'd0);
                    if (stall >= 0)
                        mem_ready = (waits >= stall);
                    else
                        mem_ready = (waits >= 6) || ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                    if (mem_ready) done = 1'b1;
                    mem_ready = 1'b0;
                    waits++;
                end
            end
            @(negedge clk);
            checkOutput("done_valid_low", 64'(mem_valid), 64'd0);
            checkOutput("done_ready", 64'(req_ready), 64'd1);
            checkOutput("done_busy_low", 64'(busy), 64'd0);
            checkOutput("done_be_zero", 64'(mem_be), 64'd0);
            checkOutput("done_wdata_zero", 64'(mem_wdata), 64'd0);
            checkOutput("done_no_err", 64'(store_err), 64'd0);
        end
    endtask

    // Asserts reset mid-store (second beat when splitting is built in,
    // otherwise the only beat) and checks the store is abandoned at once.
    task automatic resetDuringBeat();
        @(negedge clk);
        req_valid = 1'b1;
        req_func3 = 3'b010;
        req_data  = 32'hDDCC_BBAA;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        req_addr  = 32'h0000_0301;
`else
        req_addr  = 32'h0000_0300;
`endif
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'b0;
`endif
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #1;
        checkOutput("rst_pre_valid", 64'(mem_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid_low", 64'(mem_valid), 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_busy_low", 64'(busy), 64'd0);
        checkOutput("rst_be_zero", 64'(mem_be), 64'd0);
        checkOutput("rst_addr_zero", 64'(mem_addr), 64'd0);
        checkOutput("rst_wdata_zero", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_resume", 64'(mem_valid), 64'd0);
        checkOutput("rst_no_err", 64'(store_err), 64'd0);
        mem_ready = 1'b0;
    endtask

    // Main sequence: reset, directed corner cases, then random stores.
    initial begin
        logic [31:0] rAddr;
        logic [2:0]  rF3;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = 32'd0;
        req_func3 = 3'b000;
        mem_ready = 1'b0;
        #2;
        checkOutput("reset_ready", 64'(req_ready), 64'd1);
        checkOutput("reset_valid", 64'(mem_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_err", 64'(store_err), 64'd0);
        checkOutput("reset_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_be", 64'(mem_be), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h0000_0103, 32'h0000_00AB, 3'b000, 0);
        applyStimulus(32'h0000_0202, 32'h0000_1234, 3'b001, 3);
        applyStimulus(32'h0000_0301, 32'hDDCC_BBAA, 3'b010, 0);
        applyStimulus(32'hFFFF_FFFE, 32'h4433_2211, 3'b010, 1);
        applyStimulus(32'h0000_0403, 32'h0000_BEEF, 3'b001, 2);
        applyStimulus(32'h0000_0500, 32'h1122_3344, 3'b011, 0);
        applyStimulus(32'h0000_0504, 32'h1122_3344, 3'b111, 0);
        resetDuringBeat();

        for (int n = 0; n < 60; n++) begin
            rAddr = (n % 4 == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            rF3   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7))
                                                : 3'($urandom_range(0, 2));
            applyStimulus(rAddr, $urandom, rF3, -1);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
